assoc_icache: RTL
=================

ASSOC_ICACHE -- requirements
Module: assoc_icache

Interface
REQ-001 SHALL take parameters: SETS, default 8, number of sets (power of 2, 2..64); WAYS, default 2, associativity (1 or 2); BLOCK_WORDS, default 2, words per block (1, 2 or 4).
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports named CLK and nRST.
REQ-003 CLK  input  1  system clock, rising edge.
REQ-004 nRST  input  1  asynchronous active-low reset.
REQ-005 imemREN  input  1  datapath instruction fetch request.
REQ-006 imemaddr  input  32 (word_t)  fetch byte address; bits [1:0] ignored.
REQ-007 ihit  output  1  requested word valid on imemload this cycle.
REQ-008 imemload  output  32 (word_t)  fetched instruction; 0 when ihit=0.
REQ-009 inv  input  1  invalidate all lines (synchronous pulse).
REQ-010 iREN  output  1  memory read request.
REQ-011 iaddr  output  32 (word_t)  memory word address.
REQ-012 iwait  input  1  memory busy; iload valid when iREN=1 and iwait=0.
REQ-013 iload  input  32 (word_t)  memory read data.

Function
REQ-014 SHALL split imemaddr into: byte offset [1:0]; block offset log2(BLOCK_WORDS) bits; index log2(SETS) bits; tag = remaining upper bits.
REQ-015 SHALL store per way/set: valid bit, tag, and BLOCK_WORDS data words; per set, one LRU bit when WAYS=2.
REQ-016 SHALL use FSM states IDLE and FILL only.
REQ-017 IDLE: ihit SHALL be combinational, asserted when imemREN=1 and a valid way matches the tag; imemload = matching word; zero-cycle hit latency.
REQ-018 IDLE, imemREN=1 and miss: SHALL latch tag/index, select victim, clear word counter, go to FILL next edge.
REQ-019 Victim selection: first invalid way (way 0 preferred); otherwise the LRU way.
REQ-020 FILL: iREN=1; iaddr = {latched tag, latched index, counter, 2'b00}; fetch starts at block word 0 regardless of requested offset.
REQ-021 FILL: on each cycle with iwait=0, iload SHALL be written into victim word[counter] and the counter incremented.
REQ-022 FILL: on the word with counter=BLOCK_WORDS-1 and iwait=0, victim valid and tag SHALL be written and the FSM return to IDLE; ihit=0 throughout FILL.
REQ-023 Miss penalty: BLOCK_WORDS memory transactions plus one IDLE cycle for the hit.
REQ-024 LRU (WAYS=2): a hit or completed fill SHALL mark the used way MRU; with WAYS=1 the LRU bit does not exist.
REQ-025 imemREN deassertion or imemaddr change during FILL SHALL NOT abort the fill; the latched block completes.
REQ-026 inv=1 SHALL clear all valid and LRU bits at the next edge; in FILL it SHALL also abort the fill, return to IDLE, and deassert iREN next cycle without validating the victim.
REQ-027 inv and a same-cycle IDLE hit: ihit still reported that cycle; lines invalid afterwards.

Reset
REQ-028 nRST low SHALL immediately force: state IDLE, counter 0, all valid/LRU bits 0, iREN=0, iaddr=0, ihit=0, imemload=0; data/tag arrays need not reset.
REQ-029 Reset mid-fill SHALL discard the fill; no partial line is ever valid.

Structure
REQ-030 The icache state enum, the address-field struct template and the WAYS/BLOCK_WORDS legal-value constants SHALL live in cpu_types_pkg.
REQ-031 One sub-module, icache_way (tag/valid/data storage for one way, read and write ports), SHALL be instantiated WAYS times.

Verification (SETS=8, WAYS=2, BLOCK_WORDS=2 unless stated; tag [31:6], index [5:3], offset [2])
REQ-032 After reset, read 0x40 -> iREN with iaddr 0x40 then 0x44 (iwait high 2 cycles each), iload 0xAAAA0001/0xAAAA0002; then ihit, imemload=0xAAAA0001; read 0x44 -> ihit, 0xAAAA0002, iREN stays 0.
REQ-033 Fill 0x40 and 0x80 (index 0); read 0x40 (hit); read 0xC0 -> miss evicts 0x80; 0x40 then hits, 0x80 misses.
REQ-034 Drop imemREN after first word of fill of 0x100 -> second word still fetched (iaddr 0x104); later read 0x100 hits.
REQ-035 inv pulse in IDLE after 0x40 cached -> 0x40 misses again; inv during FILL -> iREN=0 next cycle, block not valid.
REQ-036 nRST low mid-fill -> iREN=0 same cycle; afterwards every address misses.
REQ-037 WAYS=1, BLOCK_WORDS=4: read 0x108 -> iaddr sequence 0x100, 0x104, 0x108, 0x10C; then ihit with word from 0x108.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared types for the instruction cache: word type, cache FSM
//                state enum, address-field layout for the default geometry,
//                and the legal associativity / block-size values.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    // Legal geometry values for the instruction cache.
    localparam int ICACHE_WAYS_MIN = 1;
    localparam int ICACHE_WAYS_MAX = 2;
    localparam int ICACHE_BLOCK_WORDS_MIN = 1;
    localparam int ICACHE_BLOCK_WORDS_MAX = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Address-field template for the default geometry (8 sets, 2 words/block).
    localparam int ICACHE_TAG_W    = 26;
    localparam int ICACHE_IDX_W    = 3;
    localparam int ICACHE_BLKOFF_W = 1;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0]    tag;
        logic [ICACHE_IDX_W-1:0]    idx;
        logic [ICACHE_BLKOFF_W-1:0] blkoff;
        logic [1:0]                 bytoff;
    } icachef_t;

    function automatic logic icache_ways_legal(input int ways);
        return (ways == 1) || (ways == 2);
    endfunction

    function automatic logic icache_block_words_legal(input int bw);
        return (bw == 1) || (bw == 2) || (bw == 4);
    endfunction

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/icache_way.sv
`default_nettype none
// ============================================================================
//  Module      : icache_way
//  Description : Storage for one cache way: per-set valid bit, tag and block
//                data. Asynchronous read of one word; word write port used
//                during a fill and a line-validate port that writes the tag.
//  Ports       : CLK, nRST        - clock, async active-low reset (valid only)
//                inv              - clear every valid bit at the next edge
//                rd_idx/rd_off    - read set index / word offset
//                rd_valid/rd_tag/rd_word - read results
//                wr_word_en/wr_idx/wr_off/wr_word - data word write
//                wr_line_en/wr_tag - mark line at wr_idx valid with wr_tag
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_way
    import cpu_types_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 2,
    parameter int TAG_W       = 26,
    parameter int IDX_W       = 3,
    parameter int OFF_W       = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inv,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output word_t            rd_word,
    input  logic             wr_word_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  word_t            wr_word,
    input  logic             wr_line_en,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    word_t            data_q [SETS][BLOCK_WORDS];

    // Invalidate wins over a same-cycle validate.
    always_comb begin
        valid_d = valid_q;
        if (inv) begin
            valid_d = '0;
        end else if (wr_line_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (wr_word_en) begin
            data_q[wr_idx][wr_off] <= wr_word;
        end
        if (wr_line_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

endmodule : icache_way
`default_nettype wire

// File: rtl/assoc_icache.sv
`default_nettype none
// ============================================================================
//  Module      : assoc_icache
//  Description : Set-associative (1 or 2 way) blocking instruction cache with
//                zero-cycle hits and a word-by-word block fill from memory.
//  Ports       : CLK, nRST            - clock, async active-low reset
//                imemREN, imemaddr    - datapath fetch request / byte address
//                ihit, imemload       - hit flag and fetched word (0 on miss)
//                inv                  - invalidate all lines (aborts a fill)
//                iREN, iaddr          - memory read request / word address
//                iwait, iload         - memory busy flag / read data
//  Revision    : 1.0 - initial release
// ============================================================================
module assoc_icache
    import cpu_types_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  inv,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int BLK_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = (BLK_W > 0) ? BLK_W : 1;
    localparam int TAG_W = WORD_W - 2 - BLK_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

    // ------------------------------------------------------------------
    // Request address fields
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;

    assign req_tag = imemaddr[WORD_W-1 -: TAG_W];
    assign req_idx = imemaddr[2+BLK_W +: IDX_W];

    if (BLK_W > 0) begin : g_blkoff
        assign req_off = imemaddr[2 +: BLK_W];
    end else begin : g_noblkoff
        assign req_off = '0;
    end

    // Byte offset is irrelevant for word fetches.
    logic unused_bytoff;
    assign unused_bytoff = ^imemaddr[1:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    icache_state_t    state_q,  state_d;
    logic [TAG_W-1:0] tag_q,    tag_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [OFF_W-1:0] cnt_q,    cnt_d;
    logic             victim_q, victim_d;

    // ------------------------------------------------------------------
    // Ways
    // ------------------------------------------------------------------
    logic             way_valid [WAYS];
    logic [TAG_W-1:0] way_tag   [WAYS];
    word_t            way_word  [WAYS];
    logic [WAYS-1:0]  way_match;
    logic [WAYS-1:0]  way_wr_word;
    logic [WAYS-1:0]  way_wr_line;
    logic             fill_word_en;
    logic             fill_done;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS        (SETS),
            .BLOCK_WORDS (BLOCK_WORDS),
            .TAG_W       (TAG_W),
            .IDX_W       (IDX_W),
            .OFF_W       (OFF_W)
        ) u_way (
            .CLK        (CLK),
            .nRST       (nRST),
            .inv        (inv),
            .rd_idx     (req_idx),
            .rd_off     (req_off),
            .rd_valid   (way_valid[w]),
            .rd_tag     (way_tag[w]),
            .rd_word    (way_word[w]),
            .wr_word_en (way_wr_word[w]),
            .wr_idx     (idx_q),
            .wr_off     (cnt_q),
            .wr_word    (iload),
            .wr_line_en (way_wr_line[w]),
            .wr_tag     (tag_q)
        );

        assign way_match[w]   = way_valid[w] && (way_tag[w] == req_tag);
        assign way_wr_word[w] = fill_word_en && (int'(victim_q) == w);
        assign way_wr_line[w] = fill_done    && (int'(victim_q) == w);
    end

    // ------------------------------------------------------------------
    // Hit detection and victim choice
    // ------------------------------------------------------------------
    logic  hit_any;
    logic  hit_way;
    word_t hit_word;
    logic  lru_way;
    logic  victim_sel;

    always_comb begin
        hit_any  = 1'b0;
        hit_way  = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_match[w]) begin
                hit_any  = 1'b1;
                hit_way  = 1'(w);
                hit_word = way_word[w];
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins; when every
    // way is valid the LRU way is evicted.
    always_comb begin
        victim_sel = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim_sel = 1'(w);
            end
        end
    end

    // ------------------------------------------------------------------
    // LRU tracking (only meaningful with two ways)
    // ------------------------------------------------------------------
    logic             lru_touch;
    logic [IDX_W-1:0] lru_touch_idx;
    logic             lru_touch_way;

    if (WAYS == 2) begin : g_lru
        // lru_q[set] holds the index of the least recently used way.
        logic [SETS-1:0] lru_q;
        logic [SETS-1:0] lru_d;

        always_comb begin
            lru_d = lru_q;
            if (inv) begin
                lru_d = '0;
            end else if (lru_touch) begin
                lru_d[lru_touch_idx] = ~lru_touch_way;
            end
        end

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                lru_q <= '0;
            end else begin
                lru_q <= lru_d;
            end
        end

        assign lru_way = lru_q[req_idx];
    end else begin : g_nolru
        assign lru_way = 1'b0;

        logic unused_lru;
        assign unused_lru = ^{lru_touch, lru_touch_idx, lru_touch_way};
    end

    // ------------------------------------------------------------------
    // Fill address: always starts from block word 0
    // ------------------------------------------------------------------
    word_t fill_addr;

    if (BLK_W > 0) begin : g_faddr_blk
        assign fill_addr = {tag_q, idx_q, cnt_q, 2'b00};
    end else begin : g_faddr_word
        assign fill_addr = {tag_q, idx_q, 2'b00};
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        victim_d      = victim_q;
        ihit          = 1'b0;
        imemload      = '0;
        iREN          = 1'b0;
        iaddr         = '0;
        fill_word_en  = 1'b0;
        fill_done     = 1'b0;
        lru_touch     = 1'b0;
        lru_touch_idx = req_idx;
        lru_touch_way = hit_way;

        case (state_q)
            IDLE: begin
                if (imemREN) begin
                    if (hit_any) begin
                        ihit      = 1'b1;
                        imemload  = hit_word;
                        lru_touch = 1'b1;
                    end else begin
                        state_d  = FILL;
                        tag_d    = req_tag;
                        idx_d    = req_idx;
                        cnt_d    = '0;
                        victim_d = victim_sel;
                    end
                end
            end

            FILL: begin
                iREN  = 1'b1;
                iaddr = fill_addr;
                // The request inputs are ignored here: the latched block
                // always completes unless invalidated.
                if (inv) begin
                    state_d = IDLE;
                end else if (!iwait) begin
                    fill_word_en = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        fill_done     = 1'b1;
                        state_d       = IDLE;
                        lru_touch     = 1'b1;
                        lru_touch_idx = idx_q;
                        lru_touch_way = victim_q;
                    end else begin
                        cnt_d = cnt_q + OFF_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
        end
    end

endmodule : assoc_icache
`default_nettype wire
